// File: rtl/sub32_serial_pkg.sv
// Shared definitions for the byte-serial subtractor: defaults, index width and FSM encoding.
package sub32_serial_pkg;

   localparam int WIDTH_DEF  = 32;
   localparam int SLICE_DEF  = 8;
   localparam int NSLICE_DEF = WIDTH_DEF / SLICE_DEF;
   localparam int IDX_W_DEF  = $clog2(NSLICE_DEF);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/cla_sub8.sv
// Combinational carry-lookahead slice; the caller supplies the already inverted subtrahend.
module cla_sub8
   import sub32_serial_pkg::*;
#(
   parameter int W = SLICE_DEF
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] s_o,
   output logic         cout_o
);

   logic [W-1:0] g;
   logic [W-1:0] p;
   logic [W:0]   c;
   logic         acc;
   logic         prod;

   assign g = a_i & b_i;
   assign p = a_i | b_i;

   // Each carry is a flat sum of products: g[j] gated by the propagates above it.
   always_comb begin
      c    = '0;
      acc  = 1'b0;
      prod = 1'b1;
      c[0] = cin_i;
      for (int i = 0; i < W; i++) begin
         acc  = 1'b0;
         prod = 1'b1;
         for (int j = i; j >= 0; j--) begin
            acc  = acc | (g[j] & prod);
            prod = prod & p[j];
         end
         c[i+1] = acc | (prod & cin_i);
      end
   end

   assign s_o    = a_i ^ b_i ^ c[W-1:0];
   assign cout_o = c[W];

endmodule

// File: rtl/sub32_serial.sv
// Byte-serial a - b with RISC-V compare flags; one lookahead slice per cycle, valid/ready on both sides.
module sub32_serial
   import sub32_serial_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SLICE = SLICE_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero,
   output logic             ovf,
   output logic             lt_s,
   output state_e           dbg_state
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   // Handshake: a transfer happens on an edge where valid and ready are both high;
   // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds until out_ready.
   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   nb_q, nb_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               borrow_q, borrow_d;
   logic               zero_q, zero_d;
   logic               ovf_q, ovf_d;
   logic               lt_s_q, lt_s_d;

   logic [SLICE-1:0]   slice_s;
   logic               slice_co;

   cla_sub8 #(.W(SLICE)) u_slice (
      .a_i    (a_q[int'(idx_q)*SLICE +: SLICE]),
      .b_i    (nb_q[int'(idx_q)*SLICE +: SLICE]),
      .cin_i  (carry_q),
      .s_o    (slice_s),
      .cout_o (slice_co)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         nb_q     <= '0;
         diff_q   <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         lt_s_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         nb_q     <= nb_d;
         diff_q   <= diff_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         borrow_q <= borrow_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         lt_s_q   <= lt_s_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      nb_d     = nb_q;
      diff_d   = diff_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      borrow_d = borrow_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      lt_s_d   = lt_s_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               nb_d    = ~b;
               carry_d = 1'b1;
               idx_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            diff_d[int'(idx_q)*SLICE +: SLICE] = slice_s;
            carry_d = slice_co;
            idx_d   = idx_q + 1'b1;
            // Flags use diff_d so the slice written on this edge is included.
            if (idx_q == IDX_W'(NSLICE - 1)) begin
               state_d  = ST_DONE;
               borrow_d = ~slice_co;
               zero_d   = (diff_d == '0);
               ovf_d    = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
               lt_s_d   = diff_d[WIDTH-1] ^ ovf_d;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign diff      = diff_q;
   assign borrow    = borrow_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;
   assign lt_s      = lt_s_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sub32_serial.sv
// Random and directed operands for sub32_serial checked against an arithmetic model of a - b.
module tb_sub32_serial;
   import sub32_serial_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, borrow, zero, ovf, lt_s;
   logic [W-1:0] diff;
   state_e       dbg_state;

   int total = 0;
   int bad = 0;
   logic [W+3:0] exp_q[$];

   always #5 clk = ~clk;

   sub32_serial dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .zero      (zero),
      .ovf       (ovf),
      .lt_s      (lt_s),
      .dbg_state (dbg_state)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic, packed as {lt_s, ovf, zero, borrow, diff}.
   function automatic logic [W+3:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] d;
      longint       sd;
      logic         o;
      d  = x - y;
      sd = longint'($signed(x)) - longint'($signed(y));
      o  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      return {($signed(x) < $signed(y)), o, (x == y), (x < y), d};
   endfunction

   function automatic logic [W+3:0] observed();
      return {lt_s, ovf, zero, borrow, diff};
   endfunction

   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input int hold, input bit poke);
      int n;
      logic [W+3:0] e;
      exp_q.push_back(model(x, y));
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check("in_ready_wait", in_ready, 1'b1);
      in_valid = 1'b1; a = x; b = y;
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom;
      n = 0;
      while (!out_valid && n < 10) begin
         check("busy_in_ready", in_ready, 1'b0);
         in_valid = (poke && n == 1);
         @(posedge clk); #1; n++;
      end
      in_valid = 1'b0;
      check("latency", n, 4);
      e = exp_q.pop_front();
      check("result", observed(), e);
      for (int k = 0; k < hold; k++) begin
         out_ready = 1'b0;
         @(posedge clk); #1;
         check("hold_result", observed(), e);
         check("hold_valid_ready", {out_valid, in_ready}, 2'b10);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("after_ack", {out_valid, in_ready}, 2'b01);
   endtask

   task automatic reset_mid(input logic [W-1:0] x, input logic [W-1:0] y);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      in_valid = 1'b1; a = x; b = y;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("pre_reset_busy", dbg_state, ST_BUSY);
      rstn = 1'b0;
      #1;
      check("mid_reset_outputs", observed(), '0);
      check("mid_reset_valid_ready", {out_valid, in_ready}, 2'b01);
      check("mid_reset_state", dbg_state, ST_IDLE);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1;
      check("reset_outputs", observed(), '0);
      check("reset_valid_ready", {out_valid, in_ready}, 2'b01);
      check("reset_state", dbg_state, ST_IDLE);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;

      do_op(32'd5, 32'd3, 0, 1'b0);
      do_op(32'd3, 32'd5, 0, 1'b0);
      do_op(32'h8000_0000, 32'd1, 1, 1'b0);
      do_op(32'h0000_0100, 32'd1, 0, 1'b0);
      do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1'b0);
      do_op(32'd0, 32'd1, 0, 1'b0);
      do_op(32'h1234_5678, 32'h0BAD_F00D, 3, 1'b1);
      reset_mid(32'hCAFE_0000, 32'h0000_0001);
      do_op(32'd10, 32'd4, 0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         do_op(pick(), pick(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
